uart_tx_arbiter: RTL

Shares the single UART tx line of the UART pin interface between NUM_REQ byte producers. Round-robin arbitration selects one producer per frame. The selected byte is serialized as a complete UART frame (start, data LSB-first, optional parity, stop) at CLK_DIV clocks per bit. The block sits between the transmit-side sequencers and the interface tx pin.

---
 rtl/uart_tx_arbiter_pkg.sv | 25 ++
 rtl/uart_rr_arbiter.sv | 59 +++++
 rtl/uart_tx_arbiter.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter.
//   uart_tx_state_e : frame sequencer states
//   DEFAULT_*       : default parameter values for the arbiter and its sub-blocks
//   wrap_inc        : modulo increment used by the round-robin pointer
package UartGlobalPkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_e;

  localparam int DEFAULT_NUM_REQ    = 4;
  localparam int DEFAULT_CLK_DIV    = 16;
  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_STOP_BITS  = 1;

  // (value + 1) mod modulus, without a divider.
  function automatic int wrap_inc(input int value, input int modulus);
    return (value + 1 >= modulus) ? 0 : value + 1;
  endfunction

endpackage

// File: rtl/uart_rr_arbiter.sv
// Round-robin arbiter: combinational grant, registered priority pointer.
// The search starts at the pointer and wraps, so the requester just served
// drops to lowest priority once the pointer advances past it.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset (pointer -> 0)
//   req         : per-requester request
//   enable      : when low, no grant is issued
//   advance     : a grant was accepted; pointer moves to grant_idx + 1
//   grant       : one-hot grant (all zero when nothing is granted)
//   grant_idx   : binary index of the granted requester (0 when none)
module uart_rr_arbiter
  import UartGlobalPkg::*;
#(
  parameter int NUM_REQ = DEFAULT_NUM_REQ
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic                       enable,
  input  logic                       advance,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] ptr_q;

  always_comb begin
    // NOTE: every variable gets a default before any conditional assignment,
    // otherwise synthesis infers a latch to hold the old value.
    int   cand;
    logic found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(ptr_q) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (enable && !found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = IDX_W'(cand);
      end
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
    end else if (advance) begin
      ptr_q <= IDX_W'(wrap_inc(int'(grant_idx), NUM_REQ));
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART tx line between NUM_REQ byte producers. A round-robin
// arbiter picks one producer per frame; the accepted byte is sent as
// start, DATA_WIDTH data bits LSB first, optional parity, STOP_BITS stop bits,
// each bit lasting CLK_DIV clocks.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   req_valid   : per-requester byte valid (must be held until accepted)
//   req_data    : packed bytes, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready   : one-hot acceptance, only ever high in IDLE
//   tx          : registered serial output, idles high
//   busy        : high from the accepting edge until the frame ends
//   grant_id    : index of the most recently accepted requester
//   frame_done  : one-cycle pulse in the first IDLE cycle after a frame
module uart_tx_arbiter
  import UartGlobalPkg::*;
#(
  parameter int NUM_REQ    = DEFAULT_NUM_REQ,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int CLK_DIV    = DEFAULT_CLK_DIV,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = DEFAULT_STOP_BITS
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          frame_done
);

  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int BAUD_W = $clog2(CLK_DIV);
  localparam int BIT_W  = $clog2(DATA_WIDTH);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);
  localparam logic              STOP_LAST = 1'(STOP_BITS - 1);

  uart_tx_state_e        state_q;
  logic                  tx_q;
  logic                  busy_q;
  logic                  frame_done_q;
  logic [IDX_W-1:0]      grant_id_q;
  logic [BAUD_W-1:0]     baud_q;
  logic [BAUD_W-1:0]     baud_d;
  logic [BIT_W-1:0]      bit_q;
  logic                  stop_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic                  parity_q;

  logic [NUM_REQ-1:0]    arb_grant;
  logic [IDX_W-1:0]      arb_idx;
  logic                  arb_enable;
  logic                  handshake;
  logic                  bit_end;
  logic [DATA_WIDTH-1:0] sel_data;

  // Gating with reset keeps req_ready low while reset is asserted, even
  // though the FSM already sits in IDLE.
  assign arb_enable = (state_q == IDLE) && !reset;

  uart_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (req_valid),
    .enable    (arb_enable),
    .advance   (handshake),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

  assign req_ready = arb_grant;
  assign handshake = |(req_valid & arb_grant);
  assign bit_end   = (baud_q == BAUD_LAST);
  assign baud_d    = bit_end ? '0 : baud_q + 1'b1;

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_grant[i]) sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      grant_id_q   <= '0;
      baud_q       <= '0;
      bit_q        <= '0;
      stop_q       <= 1'b0;
      // NOTE: the shift register is a handful of flops, not a memory, so it is
      // reset too; this keeps simulation free of X on a never-used datapath.
      shift_q      <= '0;
      parity_q     <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (state_q != IDLE) baud_q <= baud_d;

      case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (handshake) begin
            shift_q    <= sel_data;
            parity_q   <= (^sel_data) ^ (PARITY_ODD != 0);
            grant_id_q <= arb_idx;
            baud_q     <= '0;
            state_q    <= START;
            tx_q       <= 1'b0;
            busy_q     <= 1'b1;
          end
        end

        START: begin
          if (bit_end) begin
            state_q <= DATA;
            bit_q   <= '0;
            tx_q    <= shift_q[0];
            shift_q <= shift_q >> 1;
          end
        end

        DATA: begin
          if (bit_end) begin
            if (bit_q == BIT_LAST) begin
              if (PARITY_EN != 0) begin
                state_q <= PARITY;
                tx_q    <= parity_q;
              end else begin
                state_q <= STOP;
                stop_q  <= 1'b0;
                tx_q    <= 1'b1;
              end
            end else begin
              bit_q   <= bit_q + 1'b1;
              tx_q    <= shift_q[0];
              shift_q <= shift_q >> 1;
            end
          end
        end

        PARITY: begin
          if (bit_end) begin
            state_q <= STOP;
            stop_q  <= 1'b0;
            tx_q    <= 1'b1;
          end
        end

        STOP: begin
          if (bit_end) begin
            if (stop_q == STOP_LAST) begin
              state_q      <= IDLE;
              busy_q       <= 1'b0;
              frame_done_q <= 1'b1;
            end else begin
              stop_q <= stop_q + 1'b1;
            end
          end
        end

        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign grant_id   = grant_id_q;
  assign frame_done = frame_done_q;

endmodule
